// File: rtl/pfet_gm_sar_cal_if.sv
// Handshake/result bundle between the bias/trim controller and the
// pfet gm SAR calibrator. The controller is the master (drives start),
// the calibrator is the slave (drives code and status).
interface pfet_gm_sar_cal_if #(
   parameter int NBIT = 8
);
   logic            start;
   logic [NBIT-1:0] gm_code;
   logic            busy;
   logic            done;
   logic            sat_hi;

   modport master (
      output start,
      input  gm_code,
      input  busy,
      input  done,
      input  sat_hi
   );

   modport slave (
      input  start,
      output gm_code,
      output busy,
      output done,
      output sat_hi
   );
endinterface

// File: rtl/pfet_gm_sar_cal.sv
// pfet_gm_sar_cal: successive-approximation calibrator that searches the
// real transconductance gm driving a pfet model so that its drain current
// lands at or just below id_target. Each trial code is given SETTLE_CYC
// cycles to settle before id is compared in a single COMPARE cycle.
//
// Optional feature macro: PFET_CAL_TRACK_EN
//   defined   -> after the search the block stays in TRACK, nudging the
//                code by +/-1 LSB every SETTLE_CYC+1 cycles until reset.
//   undefined -> one-shot search; TRACK is not compiled.
module pfet_gm_sar_cal #(
   parameter int  NBIT       = 8,
   parameter real GM_MAX     = 2.56e-3,
   parameter int  SETTLE_CYC = 2
) (
   input  logic                   clk,
   input  logic                   rstb,
   pfet_gm_sar_cal_if.slave       cal,
   input  real                    id,
   input  real                    id_target,
   output real                    gm
);

   localparam int BIDX_W = (NBIT > 1) ? $clog2(NBIT) : 1;
   localparam int CNT_W  = $clog2(SETTLE_CYC + 1) + 1;

   localparam logic [BIDX_W-1:0] BIDX_MAX = BIDX_W'(NBIT - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
`ifdef PFET_CAL_TRACK_EN
   localparam logic [CNT_W-1:0]  CNT_TRK  = CNT_W'(SETTLE_CYC);
`endif
   localparam logic [NBIT-1:0]   CODE_MSB = {1'b1, {(NBIT-1){1'b0}}};
   localparam logic [NBIT-1:0]   CODE_MAX = {NBIT{1'b1}};

`ifdef PFET_CAL_TRACK_EN
   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_COMPARE, S_DONE, S_TRACK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_COMPARE, S_DONE
   } state_t;
`endif

   state_t            state;
   logic [NBIT-1:0]   code_q;
   logic [BIDX_W-1:0] bidx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              sat_q;

   logic              above_c;
   logic              below_c;
   logic [NBIT-1:0]   resolved_c;
   logic [NBIT-1:0]   next_trial_c;

   // Clear the bit under test when the device current overshoots.
   function automatic logic [NBIT-1:0] clear_if(input logic [NBIT-1:0] code,
                                                 input logic [BIDX_W-1:0] idx,
                                                 input logic above);
      logic [NBIT-1:0] r;
      r = code;
      if (above) r[idx] = 1'b0;
      return r;
   endfunction

   // Raise the next trial bit.
   function automatic logic [NBIT-1:0] set_bit(input logic [NBIT-1:0] code,
                                                input logic [BIDX_W-1:0] idx);
      logic [NBIT-1:0] r;
      r = code;
      r[idx] = 1'b1;
      return r;
   endfunction

   // Code to siemens conversion; one LSB is GM_MAX/2**NBIT.
   function automatic real gm_of(input logic [NBIT-1:0] code);
      return real'(code) * GM_MAX / (2.0 ** NBIT);
   endfunction

   // Compare result and candidate codes for the current COMPARE/TRACK edge.
   always_comb begin
      above_c      = (id > id_target);
      below_c      = (id < id_target);
      resolved_c   = clear_if(code_q, bidx_q, above_c);
      next_trial_c = set_bit(resolved_c, bidx_q - 1'b1);
   end

   // gm mirrors the registered code, so both change on the same edge.
   always_comb gm = gm_of(code_q);

   assign cal.gm_code = code_q;
   assign cal.busy    = busy_q;
   assign cal.done    = done_q;
   assign cal.sat_hi  = sat_q;

   // Search/track state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state  <= S_IDLE;
         code_q <= '0;
         bidx_q <= BIDX_MAX;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cal.start) begin
                  code_q <= CODE_MSB;
                  bidx_q <= BIDX_MAX;
                  sat_q  <= 1'b0;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q == CNT_LAST) begin
                  state <= S_COMPARE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_COMPARE: begin
               if (bidx_q != '0) begin
                  code_q <= next_trial_c;
                  bidx_q <= bidx_q - 1'b1;
                  cnt_q  <= '0;
                  state  <= S_SETTLE;
               end else begin
                  // Final decision: result and status appear with done.
                  code_q <= resolved_c;
                  sat_q  <= (resolved_c == CODE_MAX) && below_c;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
`ifdef PFET_CAL_TRACK_EN
               cnt_q  <= '0;
               busy_q <= 1'b1;
               state  <= S_TRACK;
`else
               state  <= S_IDLE;
`endif
            end
`ifdef PFET_CAL_TRACK_EN
            S_TRACK: begin
               if (cnt_q == CNT_TRK) begin
                  cnt_q <= '0;
                  if (above_c) begin
                     if (code_q != '0) code_q <= code_q - 1'b1;
                     sat_q <= 1'b0;
                  end else begin
                     if (code_q != CODE_MAX) code_q <= code_q + 1'b1;
                     sat_q <= (code_q == CODE_MAX) && below_c;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
